// File: rtl/clk_div_pkg.sv
// Shared defaults and named divisors for the clock-enable bank.
// Divisors are "ticks minus one": a channel loaded with D ticks every D+1 enabled cycles.
package clk_div_pkg;

    localparam int          CNT_W_DEFAULT       = 28;
    localparam int unsigned DEFAULT_DIV_DEFAULT = 0;

    localparam int unsigned SYS_CLK_HZ = 25_000_000;

    function automatic int unsigned div_for_rate(input int unsigned clk_hz,
                                                 input int unsigned tick_hz);
        return (clk_hz / tick_hz) - 1;
    endfunction

    // Tick-rate divisors at the 25 MHz board clock; clk_out runs at half the tick rate.
    localparam int unsigned DIV_FRAME_60HZ  = div_for_rate(SYS_CLK_HZ, 60);
    localparam int unsigned DIV_SPRITE_8HZ  = div_for_rate(SYS_CLK_HZ, 8);
    localparam int unsigned DIV_SOUND_8KHZ  = div_for_rate(SYS_CLK_HZ, 8_000);
    localparam int unsigned DIV_DEBOUNCE_1K = div_for_rate(SYS_CLK_HZ, 1_000);

endpackage

// File: rtl/clk_div_chan.sv
// One divider channel: period counter, shadow divisor taken at the period boundary,
// registered tick strobe and 50 % toggle output.
module clk_div_chan
    import clk_div_pkg::*;
#(
    parameter int          CNT_W       = CNT_W_DEFAULT,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [CNT_W-1:0] div_in,
    input  logic             sync,
    output logic             tick_out,
    output logic             clk_out
);

    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DEFAULT_DIV);
    localparam logic [CNT_W-1:0] ONE     = CNT_W'(1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] div_q;
    logic [CNT_W-1:0] div_s;
    logic             pend;
    logic             at_bnd;

    assign at_bnd = (cnt == div_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            div_q    <= DIV_RST;
            div_s    <= DIV_RST;
            pend     <= 1'b0;
            tick_out <= 1'b0;
            clk_out  <= 1'b0;
        end else if (sync) begin
            // Phase restart: a same-cycle load beats an older pending value.
            cnt      <= '0;
            tick_out <= 1'b0;
            clk_out  <= 1'b0;
            pend     <= 1'b0;
            if (load) begin
                div_q <= div_in;
                div_s <= div_in;
            end else if (pend) begin
                div_q <= div_s;
            end
        end else if (en && at_bnd) begin
            cnt      <= '0;
            tick_out <= 1'b1;
            clk_out  <= ~clk_out;
            pend     <= 1'b0;
            if (load) begin
                div_q <= div_in;
                div_s <= div_in;
            end else if (pend) begin
                div_q <= div_s;
            end
        end else begin
            // Mid-period or held: divisor changes are only ever queued here.
            tick_out <= 1'b0;
            if (en) begin
                cnt <= cnt + ONE;
            end
            if (load) begin
                div_s <= div_in;
                pend  <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/clk_div_bank.sv
// Bank of independent clock-enable channels sharing one clock, reset and phase sync.
// Channel i takes its divisor from div_val[i*CNT_W +: CNT_W].
module clk_div_bank
    import clk_div_pkg::*;
#(
    parameter int          NUM_CH      = 4,
    parameter int          CNT_W       = CNT_W_DEFAULT,
    parameter int unsigned DEFAULT_DIV = DEFAULT_DIV_DEFAULT
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NUM_CH-1:0]       en,
    input  logic [NUM_CH*CNT_W-1:0] div_val,
    input  logic [NUM_CH-1:0]       load,
    input  logic                    sync,
    output logic [NUM_CH-1:0]       tick_out,
    output logic [NUM_CH-1:0]       clk_out
);

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        clk_div_chan #(
            .CNT_W       (CNT_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .en       (en[i]),
            .load     (load[i]),
            .div_in   (div_val[i*CNT_W +: CNT_W]),
            .sync     (sync),
            .tick_out (tick_out[i]),
            .clk_out  (clk_out[i])
        );
    end

endmodule

// File: doc/clk_div_bank.md
# clk_div_bank

Parametrised multi-channel clock-enable and divided-clock generator. It is the successor to the single-channel toggle divider. Each channel has its own programmable divisor, a glitch-free divisor update at the period boundary, an enable, and a one-cycle tick strobe alongside the 50 % toggle output. A global sync restarts all channels in phase. It sits between the board clock and the game timing logic (frame, sprite, sound and debounce rates), so downstream logic runs on `clk` with tick enables instead of derived clocks.

## Interface
- `NUM_CH`, default 4 — number of independent channels (≥1).
- `CNT_W`, default 28 — divisor and counter width per channel.
- `DEFAULT_DIV`, default 0 — divisor loaded into every channel on reset (must fit in `CNT_W`).

- `clk`  in  1  — single system clock; all logic on its rising edge.
- `rst`  in  1  — synchronous, active-high reset.
- `en`  in  `NUM_CH`  — per-channel count enable.
- `div_val`  in  `NUM_CH*CNT_W`  — divisor for channel i at bits [i*CNT_W +: CNT_W].
- `load`  in  `NUM_CH`  — per-channel strobe; latches the channel's `div_val` slice.
- `sync`  in  1  — global phase restart.
- `tick_out`  out  `NUM_CH`  — one-cycle pulse per completed period.
- `clk_out`  out  `NUM_CH`  — toggles once per completed period (50 % duty, period 2·(D+1)).

## Operation
- Per-channel state: `cnt` (`CNT_W`), active divisor `div_q`, shadow divisor `div_s`, pending flag `pend`, registered `tick_out[i]`, `clk_out[i]`.
- Reset: `cnt` = 0, `div_q` = `div_s` = `DEFAULT_DIV`, `pend` = 0, `tick_out` = 0, `clk_out` = 0.
- Count (`en[i]` = 1, no sync):
  - `cnt` ≠ `div_q`: `cnt` +1, `tick_out` 0.
  - `cnt` = `div_q` (boundary): `cnt` ← 0, `tick_out` ← 1, `clk_out` toggles. If `pend`, then `div_q` ← `div_s` and `pend` ← 0.
- Hold (`en[i]` = 0): `cnt`, `clk_out` and `div_q` hold; `tick_out` ← 0. `load` is still accepted into `div_s`/`pend`.
- `load[i]`: `div_s` ← slice and `pend` ← 1, so the new value takes effect at the next boundary. The current period is never truncated or stretched.
- Load coinciding with a boundary: the new slice goes straight to `div_q` and is used for the period starting now; `pend` ← 0.
- Repeated loads before a boundary: the last one wins.
- `sync` (all channels, overrides `en`): `cnt` ← 0, `clk_out` ← 0, `tick_out` ← 0.
  - If `pend`, then `div_q` ← `div_s`.
  - If `load[i]` is also high, `div_q` ← slice directly.
  - `pend` ← 0.
- `rst` overrides `sync`, `load` and `en`.
- `div_q` = 0: tick every enabled cycle, and `clk_out` = `clk`/2.
- Counter arithmetic is unsigned, `CNT_W` bits, compare by equality. `cnt` never exceeds `div_q` because the divisor changes only at cnt = 0.

## Timing
- Period of channel i is `div_q`+1 enabled cycles. `clk_out` high and low phases are each `div_q`+1 enabled cycles.
- Latency: with `en` high continuously from the first edge after `rst` falls, the first `tick_out` is high after edge D+1 and stays high for exactly one cycle.
- `tick_out` and `clk_out` are registered and change on the same edge. There are no combinational input→output paths.
- `load` is visible on outputs only from the next boundary. The one exception is a boundary or `sync` in the same cycle, where it is visible immediately.
- After `sync`, channels with equal divisors and enables tick on the same edge, D+1 edges later.
- Reset mid-period discards all state. No tick is emitted on the reset edge.

## Structure
- Package `clk_div_pkg`: default constants for `CNT_W` and `DEFAULT_DIV`, plus named divisor constants used by the game (e.g. 25 MHz→60 Hz frame, 1 kHz debounce).
- Sub-module `clk_div_chan`: holds one channel (counter, shadow, pend, outputs). It is parametrised by `CNT_W` and `DEFAULT_DIV` and takes scalar `en`, `load`, a `CNT_W` divisor, and `sync`.
- `clk_div_bank` consists of a generate loop over `NUM_CH` plus slice wiring only.

## Test plan
- Reset/basic: `DEFAULT_DIV`=3, `en`=1 after `rst` → `tick_out` pulses after edges 4, 8, 12…; `clk_out` 0→1 at edge 4, 1→0 at edge 8.
- Divisor 0 and hold: load 0, then `en`=1 → tick every cycle and `clk_out` toggles every edge. Drop `en` for 5 cycles → outputs hold, `tick_out`=0, count resumes without loss.
- Boundary-safe reload: D=9, `load` 2 at cnt=4 → current period still ends at 10 cycles, the next periods are 3 cycles. `load` exactly at cnt=9 → the next period is already 3.
- Multi-channel independence plus sync: ch0 D=2, ch1 D=5 run offset; pulse `sync` → both `clk_out`=0 and cnt=0. The ticks coincide every 6 cycles (edges 6, 12 after sync), with ch0 also at 3, 9.
- Precedence: `rst`, `sync` and `load` asserted together → reset values (`DEFAULT_DIV`), no tick. `sync`+`load` together → the new divisor applies from the sync edge.
- Width edge: `CNT_W`=4, D=15 → period 16, no wrap glitch, `tick_out` width exactly 1 cycle.
